hbs_accumulator: RTL

- Downstream stage of the HBS fused multiplier array.
- Tracks which multiplier results are valid by delaying the issue strobe to match the multiplier's pipeline latency.
- Accumulates a programmable number of 32-bit products into a wide accumulator, then presents the total on a valid/ready output.
- Provides the dot-product and MAC reduction for mode 4/8/16 operation; each result word is treated as an opaque unsigned value.

---
 rtl/hbs_accumulator.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/hbs_accumulator.sv
// hbs_accumulator: delays the multiplier issue strobe, then sums len products into a wide accumulator
//
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   clear          synchronous flush of state, flags and the valid pipeline
//   mode           multiplier mode (00=4b, 01=8b, 10=16b), watched for changes mid-run
//   issue_valid    operands presented to the multiplier this cycle
//   len            products per accumulation (0 means 1), taken on the first aligned product
//   mul_result     multiplier result word, consumed only when the delayed strobe is high
//   acc_data       accumulated sum, stable while acc_valid is high
//   acc_valid      acc_data holds a completed sum
//   acc_ready      consumer accepts acc_data
//   busy           accumulating or products still in flight
//   ovf            carry-out beyond ACC_W during the current/last accumulation
//   drop_err       sticky: an aligned product arrived while the output was stalled
//   mode_err       sticky: mode changed while products were in flight or accumulating
module hbs_accumulator #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 48,
    parameter int LAT    = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [1:0]        mode,
    input  logic              issue_valid,
    input  logic [CNT_W-1:0]  len,
    input  logic [DATA_W-1:0] mul_result,
    output logic [ACC_W-1:0]  acc_data,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic              busy,
    output logic              ovf,
    output logic              drop_err,
    output logic              mode_err
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t             state_q, state_d;
    logic [LAT-1:0]     vsr_q, vsr_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [1:0]         mode_q, mode_d;
    logic [1:0]         mode_p_q;
    logic               ovf_q, ovf_d;
    logic               drop_q, drop_d;
    logic               merr_q, merr_d;
    logic               acc_valid_q;
    logic               busy_q;

    logic               aligned;
    logic               start;
    logic [CNT_W-1:0]   len_eff;
    logic [CNT_W-1:0]   cnt_inc;
    logic [ACC_W:0]     sum;

    assign aligned = vsr_q[LAT-1];
    assign len_eff = (len == '0) ? CNT_W'(1) : len;
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign sum     = {1'b0, acc_q} + (ACC_W+1)'(mul_result);
    // A new run begins from IDLE, or from HOLD when the old sum is taken in the same cycle.
    assign start   = aligned && (state_q == IDLE || (state_q == HOLD && acc_ready));
    // Casting {vsr, in} down to LAT bits shifts the strobe in and drops the oldest bit.
    assign vsr_d   = LAT'({vsr_q, issue_valid});

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        mode_d  = mode_q;
        ovf_d   = ovf_q;
        drop_d  = drop_q | (state_q == HOLD && aligned && !acc_ready);
        merr_d  = merr_q | (state_q == ACCUM && mode != mode_q) | ((|vsr_q) && mode != mode_p_q);
        if (start) begin
            acc_d   = ACC_W'(mul_result);
            cnt_d   = CNT_W'(1);
            len_d   = len_eff;
            mode_d  = mode;
            ovf_d   = 1'b0;
            state_d = (len_eff == CNT_W'(1)) ? HOLD : ACCUM;
        end else if (state_q == ACCUM && aligned) begin
            acc_d   = sum[ACC_W-1:0];
            ovf_d   = ovf_q | sum[ACC_W];
            cnt_d   = (cnt_q == len_q) ? cnt_q : cnt_inc;
            state_d = (cnt_inc == len_q) ? HOLD : ACCUM;
        end else if (state_q == HOLD && acc_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vsr_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            mode_q      <= '0;
            mode_p_q    <= '0;
            ovf_q       <= 1'b0;
            drop_q      <= 1'b0;
            merr_q      <= 1'b0;
            acc_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (clear) begin
            state_q     <= IDLE;
            vsr_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            mode_q      <= '0;
            mode_p_q    <= mode;
            ovf_q       <= 1'b0;
            drop_q      <= 1'b0;
            merr_q      <= 1'b0;
            acc_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vsr_q       <= vsr_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            mode_q      <= mode_d;
            mode_p_q    <= mode;
            ovf_q       <= ovf_d;
            drop_q      <= drop_d;
            merr_q      <= merr_d;
            acc_valid_q <= (state_d == HOLD);
            busy_q      <= (state_d == ACCUM) || (|vsr_d);
        end
    end

    assign acc_data  = acc_q;
    assign acc_valid = acc_valid_q;
    assign busy      = busy_q;
    assign ovf       = ovf_q;
    assign drop_err  = drop_q;
    assign mode_err  = merr_q;

endmodule
